ai_controller: RTL



---
 rtl/ai_controller_pkg.sv | 24 ++
 rtl/ai_controller_if.sv | 24 ++
 rtl/ai_controller.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ai_controller_pkg.sv
// Shared game definitions: AI state encodings, arena limits and a distance helper.
package ai_controller_pkg;

    typedef enum logic [2:0] {
        AI_IDLE     = 3'd0,
        AI_WAIT     = 3'd1,
        AI_APPROACH = 3'd2,
        AI_ATTACK   = 3'd3,
        AI_RETREAT  = 3'd4,
        AI_COOLDOWN = 3'd5
    } ai_state_e;

    localparam logic [9:0] ARENA_MIN = 10'd0;
    localparam logic [9:0] ARENA_MAX = 10'd600;

    function automatic logic [9:0] abs_diff10(input logic [9:0] a, input logic [9:0] b);
        if (a >= b) begin
            return a - b;
        end else begin
            return b - a;
        end
    endfunction

endpackage

// File: rtl/ai_controller_if.sv
// Command/position bundle between the game top and the computer opponent.
interface ai_controller_if;
    import ai_controller_pkg::*;

    logic        enable;
    logic [9:0]  self_posx;
    logic [9:0]  opp_posx;
    logic [31:0] rand_i;
    logic        left;
    logic        right;
    logic        attack;
    logic [2:0]  ai_state;

    modport master (
        output enable, self_posx, opp_posx, rand_i,
        input  left, right, attack, ai_state
    );

    modport slave (
        input  enable, self_posx, opp_posx, rand_i,
        output left, right, attack, ai_state
    );

endinterface

// File: rtl/ai_controller.sv
// Computer opponent: reads both player positions and drives the controlled
// player's left/right/attack commands through a timed decision FSM.
module ai_controller
    import ai_controller_pkg::*;
#(
    parameter logic [9:0] ATTACK_RANGE    = 10'd48,
    parameter int          REACTION_CYCLES = 4,
    parameter int          ATTACK_HOLD     = 4,
    parameter int          RETREAT_CYCLES  = 8,
    parameter int          COOLDOWN_CYCLES = 12
) (
    input  logic            effective_clk,
    input  logic            reset,
    ai_controller_if.slave  bus
);

    localparam logic [7:0] REACT_LOAD    = 8'(REACTION_CYCLES - 1);
    localparam logic [7:0] HOLD_LOAD     = 8'(ATTACK_HOLD - 1);
    localparam logic [7:0] RETREAT_LOAD  = 8'(RETREAT_CYCLES - 1);
    localparam logic [7:0] COOLDOWN_LOAD = 8'(COOLDOWN_CYCLES - 1);

    ai_state_e  state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       left_q, left_d;
    logic       right_q, right_d;
    logic       attack_q, attack_d;

    logic [9:0] dist_s;
    logic       in_range_s;
    logic       toward_left_s, toward_right_s;
    logic       away_left_s, away_right_s;
    logic [7:0] wait_load_s;
    logic       unused_rand_s;

    assign dist_s         = abs_diff10(bus.self_posx, bus.opp_posx);
    assign in_range_s     = (dist_s <= ATTACK_RANGE);
    assign toward_left_s  = (bus.opp_posx < bus.self_posx);
    assign toward_right_s = (bus.opp_posx > bus.self_posx);
    // Backing away must never push the player into a wall.
    assign away_left_s    = toward_right_s && (bus.self_posx > ARENA_MIN);
    assign away_right_s   = toward_left_s  && (bus.self_posx < ARENA_MAX);
    assign wait_load_s    = REACT_LOAD + {6'd0, bus.rand_i[1:0]};
    assign unused_rand_s  = ^{bus.rand_i[31:4], bus.rand_i[2]};

    // State, timer and command registers.
    always_ff @(posedge effective_clk or posedge reset) begin
        if (reset) begin
            state_q  <= AI_IDLE;
            timer_q  <= 8'd0;
            left_q   <= 1'b0;
            right_q  <= 1'b0;
            attack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            left_q   <= left_d;
            right_q  <= right_d;
            attack_q <= attack_d;
        end
    end

    // Next-state and timer decision.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (!bus.enable) begin
            state_d = AI_IDLE;
            timer_d = 8'd0;
        end else begin
            case (state_q)
                AI_IDLE: begin
                    state_d = AI_WAIT;
                    timer_d = wait_load_s;
                end
                AI_WAIT: begin
                    if (timer_q != 8'd0) begin
                        timer_d = timer_q - 8'd1;
                    end else if (in_range_s) begin
                        state_d = AI_ATTACK;
                        timer_d = HOLD_LOAD;
                    end else begin
                        state_d = AI_APPROACH;
                        timer_d = 8'd0;
                    end
                end
                AI_APPROACH: begin
                    if (in_range_s) begin
                        state_d = AI_ATTACK;
                        timer_d = HOLD_LOAD;
                    end else begin
                        timer_d = 8'd0;
                    end
                end
                AI_ATTACK: begin
                    if (timer_q != 8'd0) begin
                        timer_d = timer_q - 8'd1;
                    end else if (bus.rand_i[3]) begin
                        state_d = AI_RETREAT;
                        timer_d = RETREAT_LOAD;
                    end else begin
                        state_d = AI_COOLDOWN;
                        timer_d = COOLDOWN_LOAD;
                    end
                end
                AI_RETREAT: begin
                    if (timer_q != 8'd0) begin
                        timer_d = timer_q - 8'd1;
                    end else begin
                        state_d = AI_COOLDOWN;
                        timer_d = COOLDOWN_LOAD;
                    end
                end
                AI_COOLDOWN: begin
                    if (timer_q != 8'd0) begin
                        timer_d = timer_q - 8'd1;
                    end else begin
                        state_d = AI_WAIT;
                        timer_d = wait_load_s;
                    end
                end
                default: begin
                    state_d = AI_IDLE;
                    timer_d = 8'd0;
                end
            endcase
        end
    end

    // Commands follow the state being entered so they switch on the same edge.
    always_comb begin
        left_d   = 1'b0;
        right_d  = 1'b0;
        attack_d = 1'b0;
        case (state_d)
            AI_APPROACH: begin
                left_d  = toward_left_s;
                right_d = toward_right_s;
            end
            AI_RETREAT: begin
                left_d  = away_left_s;
                right_d = away_right_s;
            end
            AI_ATTACK: begin
                attack_d = 1'b1;
            end
            default: begin
                left_d   = 1'b0;
                right_d  = 1'b0;
                attack_d = 1'b0;
            end
        endcase
    end

    assign bus.left     = left_q;
    assign bus.right    = right_q;
    assign bus.attack   = attack_q;
    assign bus.ai_state = state_q;

endmodule
